// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register types: stage occupancy encoding, the NOP control word
// and the packed payload layout used by the ID/EX stage wrapper.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } pipe_state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       branch;
        logic       jump;
    } rv32i_control_word_t;

    // An all-zero control word writes nothing and touches no memory, i.e. a bubble.
    localparam rv32i_control_word_t PIPE_NOP_CW = '0;

    typedef struct packed {
        rv32i_control_word_t cw;
        logic [31:0]         pc;
        logic [31:0]         rs1_val;
        logic [31:0]         rs2_val;
        logic [31:0]         imm;
        logic [4:0]          rd;
    } id_ex_payload_t;

    function automatic pipe_state_t pipe_state(input logic main_valid, input logic skid_valid);
        return skid_valid ? FULL : (main_valid ? BUSY : EMPTY);
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), synchronous flush to NOP and a stall counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 128,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter bit               SKID      = 1'b1,
    parameter int unsigned      CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;
    pipe_state_t      state_dbg;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : NOP_VALUE;

    generate
        if (SKID) begin : g_skid
            // The skid slot only fills when main is occupied and not draining,
            // so in_ready depends on state alone and never on out_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_valid <= 1'b0;
                    skid_data  <= NOP_VALUE;
                end else if (flush) begin
                    skid_valid <= 1'b0;
                    skid_data  <= NOP_VALUE;
                end else if (skid_valid) begin
                    if (out_fire) begin
                        skid_valid <= 1'b0;
                    end
                end else if (in_fire && main_valid && !out_ready) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
            end

            assign in_ready = ~skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = NOP_VALUE;
            assign in_ready   = ~main_valid | out_ready;
        end
    endgenerate

    // Main slot: when the skid holds data it refills main first to keep FIFO order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VALUE;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VALUE;
        end else if (skid_valid) begin
            if (out_fire) begin
                main_data <= skid_data;
            end
        end else if (!main_valid || out_fire) begin
            main_valid <= in_fire;
            if (in_fire) begin
                main_data <= in_data;
            end
        end
    end

    pipe_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (main_valid & ~out_ready & ~flush),
        .count (stall_cnt)
    );

    assign state_dbg = pipe_state(main_valid, skid_valid);

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(skid_valid && !main_valid));
            assert (SKID || (state_dbg != FULL));
        end
    end

endmodule
